// File: rtl/countdown_preset_ctrl.sv
// rtl/countdown_preset_ctrl.sv - count-down preset entry, load strobe and end-of-count alarm
module countdown_preset_ctrl #(
    parameter int MAX_MIN      = 59,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int ALARM_TICKS  = 3000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       set_btn,
    input  logic       inc_btn,
    input  logic       dec_btn,
    input  logic       running,
    input  logic       dir,
    input  logic       at_zero,
    output logic [6:0] preset_min,
    output logic [5:0] preset_sec,
    output logic       load_pulse,
    output logic [1:0] edit_mode,
    output logic       alarm
);

    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int ALARM_W  = $clog2(ALARM_TICKS + 1);

    localparam logic [6:0]         MAX_MIN_V   = 7'(MAX_MIN);
    localparam logic [5:0]         MAX_SEC_V   = 6'd59;
    localparam logic [HOLD_W-1:0]  DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0]  RATE_LAST   = HOLD_W'(REPEAT_RATE - 1);
    localparam logic [ALARM_W-1:0] ALARM_LAST  = ALARM_W'(ALARM_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SET_MIN = 2'd1,
        S_SET_SEC = 2'd2,
        S_ALARM   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [6:0]         r_min;
    logic [6:0]         w_min_nxt;
    logic [5:0]         r_sec;
    logic [5:0]         w_sec_nxt;
    logic               r_load;
    logic               w_load_nxt;
    logic [1:0]         r_edit;
    logic [1:0]         w_edit_nxt;
    logic               r_alarm;
    logic               w_alarm_nxt;
    logic [ALARM_W-1:0] r_alarm_cnt;
    logic [ALARM_W-1:0] w_alarm_cnt_nxt;

    // Previous samples for rise detection
    logic r_set_q;
    logic r_inc_q;
    logic r_dec_q;
    logic r_zero_q;

    // Auto-repeat state shared by inc and dec (only one can be active at a time)
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              r_repeating;
    logic              w_rep_nxt;

    logic w_set_rise;
    logic w_inc_rise;
    logic w_dec_rise;
    logic w_zero_rise;
    logic w_any_rise;
    logic w_inc_only;
    logic w_dec_only;
    logic w_step;
    logic w_step_inc;
    logic w_step_dec;

    assign w_set_rise  = set_btn & ~r_set_q;
    assign w_inc_rise  = inc_btn & ~r_inc_q;
    assign w_dec_rise  = dec_btn & ~r_dec_q;
    assign w_zero_rise = at_zero & ~r_zero_q;
    assign w_any_rise  = w_set_rise | w_inc_rise | w_dec_rise;
    assign w_inc_only  = inc_btn & ~dec_btn;
    assign w_dec_only  = dec_btn & ~inc_btn;
    assign w_step_inc  = w_step & w_inc_only;
    assign w_step_dec  = w_step & w_dec_only;

    // Register button and at_zero samples for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_set_q  <= 1'b0;
            r_inc_q  <= 1'b0;
            r_dec_q  <= 1'b0;
            r_zero_q <= 1'b0;
        end else begin
            r_set_q  <= set_btn;
            r_inc_q  <= inc_btn;
            r_dec_q  <= dec_btn;
            r_zero_q <= at_zero;
        end
    end

    // Step generation: immediate step on rise, then delay and periodic repeat while held
    always_comb begin
        w_hold_nxt = r_hold_cnt;
        w_rep_nxt  = r_repeating;
        w_step     = 1'b0;
        if (!(w_inc_only || w_dec_only)) begin
            // Released, or both held together: no steps, restart the hold timing
            w_hold_nxt = '0;
            w_rep_nxt  = 1'b0;
        end else if ((w_inc_only && w_inc_rise) || (w_dec_only && w_dec_rise)) begin
            w_hold_nxt = '0;
            w_rep_nxt  = 1'b0;
            w_step     = 1'b1;
        end else if (tick) begin
            if (!r_repeating) begin
                if (r_hold_cnt >= DELAY_LAST) begin
                    w_step     = 1'b1;
                    w_rep_nxt  = 1'b1;
                    w_hold_nxt = '0;
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end else begin
                if (r_hold_cnt >= RATE_LAST) begin
                    w_step     = 1'b1;
                    w_hold_nxt = '0;
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
        end
    end

    // Hold counter and repeat flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt  <= '0;
            r_repeating <= 1'b0;
        end else begin
            r_hold_cnt  <= w_hold_nxt;
            r_repeating <= w_rep_nxt;
        end
    end

    // Next-state, preset stepping and registered-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_min_nxt       = r_min;
        w_sec_nxt       = r_sec;
        w_load_nxt      = 1'b0;
        w_alarm_cnt_nxt = r_alarm_cnt;
        w_edit_nxt      = 2'd0;
        w_alarm_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_zero_rise && running && !dir) begin
                    w_state_nxt     = S_ALARM;
                    w_alarm_cnt_nxt = '0;
                end else if (w_set_rise && !running) begin
                    w_state_nxt = S_SET_MIN;
                end
            end
            S_SET_MIN: begin
                if (running) begin
                    w_state_nxt = S_IDLE;
                end else if (w_set_rise) begin
                    w_state_nxt = S_SET_SEC;
                end else if (w_step_inc) begin
                    w_min_nxt = (r_min >= MAX_MIN_V) ? 7'd0 : r_min + 7'd1;
                end else if (w_step_dec) begin
                    w_min_nxt = (r_min == 7'd0 || r_min > MAX_MIN_V) ? MAX_MIN_V : r_min - 7'd1;
                end
            end
            S_SET_SEC: begin
                if (running) begin
                    w_state_nxt = S_IDLE;
                end else if (w_set_rise) begin
                    w_state_nxt = S_IDLE;
                    w_load_nxt  = 1'b1;
                end else if (w_step_inc) begin
                    w_sec_nxt = (r_sec >= MAX_SEC_V) ? 6'd0 : r_sec + 6'd1;
                end else if (w_step_dec) begin
                    w_sec_nxt = (r_sec == 6'd0 || r_sec > MAX_SEC_V) ? MAX_SEC_V : r_sec - 6'd1;
                end
            end
            S_ALARM: begin
                // Any button rise acknowledges and is swallowed here
                if (w_any_rise) begin
                    w_state_nxt = S_IDLE;
                end else if (tick) begin
                    if (r_alarm_cnt >= ALARM_LAST) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_alarm_cnt_nxt = r_alarm_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        case (w_state_nxt)
            S_SET_MIN: w_edit_nxt = 2'd1;
            S_SET_SEC: w_edit_nxt = 2'd2;
            default:   w_edit_nxt = 2'd0;
        endcase
        w_alarm_nxt = (w_state_nxt == S_ALARM);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_min       <= 7'd1;
            r_sec       <= 6'd0;
            r_load      <= 1'b0;
            r_edit      <= 2'd0;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_min       <= w_min_nxt;
            r_sec       <= w_sec_nxt;
            r_load      <= w_load_nxt;
            r_edit      <= w_edit_nxt;
            r_alarm     <= w_alarm_nxt;
            r_alarm_cnt <= w_alarm_cnt_nxt;
        end
    end

    assign preset_min = r_min;
    assign preset_sec = r_sec;
    assign load_pulse = r_load;
    assign edit_mode  = r_edit;
    assign alarm      = r_alarm;

endmodule

// File: tb/tb_countdown_preset_ctrl.sv
// tb/tb_countdown_preset_ctrl.sv - directed vector bench for countdown_preset_ctrl
module tb_countdown_preset_ctrl;

    localparam int P_MAX_MIN = 59;
    localparam int P_DELAY   = 5;
    localparam int P_RATE    = 3;
    localparam int P_ALARM   = 10;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       set_btn;
    logic       inc_btn;
    logic       dec_btn;
    logic       running;
    logic       dir;
    logic       at_zero;
    logic [6:0] preset_min;
    logic [5:0] preset_sec;
    logic       load_pulse;
    logic [1:0] edit_mode;
    logic       alarm;

    int tests;
    int fails;

    typedef struct {
        logic       set;
        logic       inc;
        logic       dec;
        logic       run;
        logic [6:0] min;
        logic [5:0] sec;
        logic [1:0] edit;
        logic       load;
        logic       alm;
    } vec_t;

    vec_t vecs[$];

    countdown_preset_ctrl #(
        .MAX_MIN     (P_MAX_MIN),
        .REPEAT_DELAY(P_DELAY),
        .REPEAT_RATE (P_RATE),
        .ALARM_TICKS (P_ALARM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .set_btn   (set_btn),
        .inc_btn   (inc_btn),
        .dec_btn   (dec_btn),
        .running   (running),
        .dir       (dir),
        .at_zero   (at_zero),
        .preset_min(preset_min),
        .preset_sec(preset_sec),
        .load_pulse(load_pulse),
        .edit_mode (edit_mode),
        .alarm     (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic s, input logic i, input logic d, input logic r,
                                 input int mn, input int sc, input int ed, input logic ld,
                                 input logic al);
        vec_t v;
        v.set  = s;
        v.inc  = i;
        v.dec  = d;
        v.run  = r;
        v.min  = 7'(mn);
        v.sec  = 6'(sc);
        v.edit = 2'(ed);
        v.load = ld;
        v.alm  = al;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            cycle();
        end
    endtask

    // 0 = set, 1 = inc, 2 = dec; one-cycle press then release
    task automatic press(input int which);
        if (which == 0) set_btn = 1'b1;
        if (which == 1) inc_btn = 1'b1;
        if (which == 2) dec_btn = 1'b1;
        cycle();
        set_btn = 1'b0;
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        cycle();
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b0;
        tick    = 1'b0;
        set_btn = 1'b0;
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        running = 1'b0;
        dir     = 1'b1;
        at_zero = 1'b0;

        cycle();
        cycle();
        chk("rst_min", preset_min, 1);
        chk("rst_sec", preset_sec, 0);
        chk("rst_edit", edit_mode, 0);
        chk("rst_load", load_pulse, 0);
        chk("rst_alarm", alarm, 0);
        rst_n = 1'b1;
        cycle();

        // Edit-and-load walk, guards in IDLE
        //                 set  inc  dec  run  min sec ed ld  al
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0, 1,  0, 0,1'b0,1'b0));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b0, 1,  0, 1,1'b0,1'b0));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0, 1,  0, 1,1'b0,1'b0));
        vecs.push_back(mkv(1'b0,1'b1,1'b0,1'b0, 2,  0, 1,1'b0,1'b0));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0, 2,  0, 1,1'b0,1'b0));
        vecs.push_back(mkv(1'b0,1'b1,1'b0,1'b0, 3,  0, 1,1'b0,1'b0));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0, 3,  0, 1,1'b0,1'b0));
        vecs.push_back(mkv(1'b0,1'b1,1'b0,1'b0, 4,  0, 1,1'b0,1'b0));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0, 4,  0, 1,1'b0,1'b0));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b0, 4,  0, 2,1'b0,1'b0));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0, 4,  0, 2,1'b0,1'b0));
        vecs.push_back(mkv(1'b0,1'b0,1'b1,1'b0, 4, 59, 2,1'b0,1'b0));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0, 4, 59, 2,1'b0,1'b0));
        vecs.push_back(mkv(1'b0,1'b0,1'b1,1'b0, 4, 58, 2,1'b0,1'b0));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0, 4, 58, 2,1'b0,1'b0));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b0, 4, 58, 0,1'b1,1'b0));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0, 4, 58, 0,1'b0,1'b0));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b1, 4, 58, 0,1'b0,1'b0));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b1, 4, 58, 0,1'b0,1'b0));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0, 4, 58, 0,1'b0,1'b0));
        vecs.push_back(mkv(1'b0,1'b1,1'b0,1'b0, 4, 58, 0,1'b0,1'b0));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0, 4, 58, 0,1'b0,1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            set_btn = vecs[i].set;
            inc_btn = vecs[i].inc;
            dec_btn = vecs[i].dec;
            running = vecs[i].run;
            cycle();
            tests++;
            if ({preset_min, preset_sec, edit_mode, load_pulse, alarm} !==
                {vecs[i].min, vecs[i].sec, vecs[i].edit, vecs[i].load, vecs[i].alm}) begin
                fails++;
                $display("FAIL vec%0d: got %0d:%0d edit=%0d load=%0d alarm=%0d expected %0d:%0d edit=%0d load=%0d alarm=%0d",
                         i, preset_min, preset_sec, edit_mode, load_pulse, alarm,
                         vecs[i].min, vecs[i].sec, vecs[i].edit, vecs[i].load, vecs[i].alm);
            end
        end

        // Minute wrap both ways
        press(0);
        chk("min_edit", edit_mode, 1);
        for (int k = 0; k < 4; k++) press(2);
        chk("min_to0", preset_min, 0);
        press(2);
        chk("min_wrap_dec", preset_min, 59);
        press(1);
        chk("min_wrap_inc", preset_min, 0);

        // Second wrap 59 -> 0
        press(0);
        chk("sec_edit", edit_mode, 2);
        press(1);
        chk("sec_59", preset_sec, 59);
        press(1);
        chk("sec_wrap_inc", preset_sec, 0);

        // inc and dec together: no steps even while held over many ticks
        inc_btn = 1'b1;
        dec_btn = 1'b1;
        cycle();
        chk("both_rise", preset_sec, 0);
        tick_n(20);
        chk("both_held", preset_sec, 0);
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        cycle();

        // Auto-repeat: 1 edge + 1 after delay + 3 at rate
        inc_btn = 1'b1;
        cycle();
        chk("rep_edge", preset_sec, 1);
        tick_n(P_DELAY - 1);
        chk("rep_before_delay", preset_sec, 1);
        tick_n(1);
        chk("rep_delay", preset_sec, 2);
        tick_n(3 * P_RATE);
        chk("rep_total", preset_sec, 5);
        inc_btn = 1'b0;
        cycle();
        set_btn = 1'b1;
        cycle();
        chk("load_hi", load_pulse, 1);
        chk("load_edit", edit_mode, 0);
        set_btn = 1'b0;
        cycle();
        chk("load_lo", load_pulse, 0);

        // running during SET_MIN aborts without load, keeps edit
        press(0);
        press(1);
        chk("abort_min_pre", preset_min, 1);
        running = 1'b1;
        cycle();
        chk("abort_edit", edit_mode, 0);
        chk("abort_load", load_pulse, 0);
        chk("abort_min", preset_min, 1);
        running = 1'b0;
        cycle();

        // Alarm timeout after exactly ALARM ticks
        running = 1'b1;
        dir     = 1'b0;
        cycle();
        at_zero = 1'b1;
        cycle();
        chk("alarm_on", alarm, 1);
        tick_n(P_ALARM - 1);
        chk("alarm_hold", alarm, 1);
        tick_n(1);
        chk("alarm_timeout", alarm, 0);

        // Alarm acknowledged by set rise, which is consumed
        at_zero = 1'b0;
        cycle();
        at_zero = 1'b1;
        cycle();
        chk("alarm2_on", alarm, 1);
        running = 1'b0;
        cycle();
        chk("alarm2_still", alarm, 1);
        set_btn = 1'b1;
        cycle();
        chk("alarm_ack", alarm, 0);
        chk("ack_edit", edit_mode, 0);
        set_btn = 1'b0;
        cycle();
        chk("ack_edit_after", edit_mode, 0);
        at_zero = 1'b0;
        cycle();

        // Counting up through zero raises no alarm
        running = 1'b1;
        dir     = 1'b1;
        cycle();
        at_zero = 1'b1;
        cycle();
        chk("up_no_alarm", alarm, 0);
        running = 1'b0;
        at_zero = 1'b0;
        cycle();

        // Async reset in the middle of editing seconds
        press(0);
        press(0);
        for (int k = 0; k < 18; k++) press(1);
        chk("pre_rst_sec", preset_sec, 23);
        chk("pre_rst_edit", edit_mode, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_min", preset_min, 1);
        chk("arst_sec", preset_sec, 0);
        chk("arst_edit", edit_mode, 0);
        chk("arst_alarm", alarm, 0);
        chk("arst_load", load_pulse, 0);
        cycle();
        rst_n = 1'b1;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/countdown_preset_ctrl.md
Name: countdown_preset_ctrl

Overview:
Sequences preset entry and end-of-count alarm for the stopwatch's count-down mode. User enters mm:ss with set/inc/dec buttons while the stopwatch is stopped. The block issues a one-cycle load strobe to the time counter and raises an alarm when a count-down reaches zero. It sits between the debounced button inputs, the stopwatch run/direction controller and the mm:ss counter datapath.

Parameters:
MAX_MIN, 59, highest settable minute value (must be ≤ 99); minute field wraps MAX_MIN↔0.
REPEAT_DELAY, 500, tick count an inc/dec button must be held before auto-repeat starts.
REPEAT_RATE, 100, tick count between auto-repeat steps once repeating.
ALARM_TICKS, 3000, tick count the alarm stays on if not acknowledged.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle time-base strobe (1 kHz nominal); all delays are counted in ticks
set_btn  in  1  debounced level, set/advance button
inc_btn  in  1  debounced level, increment
dec_btn  in  1  debounced level, decrement
running  in  1  stopwatch running flag
dir  in  1  count direction (1 = up, 0 = down)
at_zero  in  1  counter reads 00:00
preset_min  out  7  preset minutes, binary 0..MAX_MIN
preset_sec  out  6  preset seconds, binary 0..59
load_pulse  out  1  one-cycle strobe: counter loads preset_min:preset_sec
edit_mode  out  2  0 = none, 1 = editing minutes, 2 = editing seconds (display blink select)
alarm  out  1  alarm/beeper enable

Behaviour:
- Reset (async, rst_n low): state IDLE, preset_min=1, preset_sec=0, load_pulse=0, edit_mode=0, alarm=0, all edge and repeat registers cleared.
- Edge detect: each button is registered once. A rise means current sample = 1 and previous sample = 0. at_zero is edge-detected the same way. All FSM actions occur on the clock edge that samples the rise.
- States: IDLE, SET_MIN, SET_SEC, ALARM. All outputs are registered.
- IDLE, set rise, running=0: go to SET_MIN, edit_mode=1.
- IDLE, set rise, running=1: ignored.
- IDLE, inc/dec: ignored.
- SET_MIN: an inc step does preset_min+1, wrapping MAX_MIN→0. A dec step does preset_min−1, wrapping 0→MAX_MIN. Set rise goes to SET_SEC, edit_mode=2.
- SET_SEC: same stepping on preset_sec with range 0..59. Set rise goes to IDLE, edit_mode=0, and load_pulse=1 for exactly that one cycle.
- SET_MIN/SET_SEC with running=1: abort to IDLE. No load_pulse; preset values are kept as edited.
- Step generation:
  - A button rise gives one step immediately.
  - While the button stays held, the hold counter advances on each tick. The first repeat step comes when REPEAT_DELAY ticks have elapsed since the rise. Further steps follow every REPEAT_RATE ticks.
  - Release clears the hold counter.
  - inc and dec high together (including a simultaneous rise): no step, hold counter cleared.
- ALARM entry: from IDLE, when at_zero rises while running=1 and dir=0. Sets alarm=1 and clears the alarm tick counter.
- ALARM exit: to IDLE with alarm=0 after ALARM_TICKS ticks, or on any button rise, whichever comes first. The exiting button rise is consumed, so a set rise that ends an alarm does not enter SET_MIN.
- at_zero rise with dir=1, or while not in IDLE: no effect.
- load_pulse is never high in two consecutive cycles. alarm is high only in ALARM.
- Counters saturate/clear and never wrap. Repeat and alarm counters are sized from their parameters.

Test Plan:
- Reset mid-edit (state SET_SEC, preset_sec=23), assert rst_n=0 → immediately preset_min=1, preset_sec=0, edit_mode=0, alarm=0, load_pulse=0.
- Edit and load (running=0): set rise, 3 inc rises, set rise, 2 dec rises from sec=0, set rise → preset 04:58, edit_mode sequence 1→2→0, load_pulse high exactly one cycle.
- Auto-repeat: in SET_SEC from 0, hold inc for REPEAT_DELAY + 3·REPEAT_RATE ticks → preset_sec=5 (1 edge + 1 delay + 3 repeat).
- Wrap boundaries: min 0 dec → 59; sec 59 inc → 0.
- Guards: set rise while running=1 → no state change. Inc+dec held together → no steps. running rises during SET_MIN → IDLE, no load_pulse.
- Alarm: dir=0, running=1, at_zero rises → alarm=1. It clears after exactly ALARM_TICKS ticks. A repeat run acknowledged by a set rise → alarm=0 next cycle, edit_mode stays 0.
